// File: rtl/split_parallel_if.sv
// ============================================================================
// split_parallel_if : merged input stream plus the two split output streams
// Revision: 1.0
// ============================================================================
`default_nettype none

interface split_parallel_if #(
   parameter int OutWidth1 = 3,
   parameter int OutWidth2 = 8
);
   localparam int InWidth = OutWidth1 + OutWidth2;

   logic                 s_valid;
   logic                 s_ready;
   logic [InWidth-1:0]   s_data;
   logic                 m_valid_1;
   logic                 m_ready_1;
   logic [OutWidth1-1:0] m_data_1;
   logic                 m_valid_2;
   logic                 m_ready_2;
   logic [OutWidth2-1:0] m_data_2;

   // Environment view: drives the merged word and both consumer readies.
   modport master (
      output s_valid, s_data, m_ready_1, m_ready_2,
      input  s_ready, m_valid_1, m_data_1, m_valid_2, m_data_2
   );

   // Splitter view.
   modport slave (
      input  s_valid, s_data, m_ready_1, m_ready_2,
      output s_ready, m_valid_1, m_data_1, m_valid_2, m_data_2
   );
endinterface

`default_nettype wire

// File: rtl/split_parallel.sv
// ============================================================================
// split_parallel : splits one merged word into two buffered valid/ready streams
// Revision: 1.0
// ============================================================================
`default_nettype none

module split_parallel #(
   parameter int OutWidth1 = 3,
   parameter int OutWidth2 = 8
) (
   input  wire              clk,
   input  wire              aresetn,
   split_parallel_if.slave  bus
);
   localparam int InWidth = OutWidth1 + OutWidth2;

   logic                       rst_done_q, rst_done_d;
   logic [1:0]                 cnt1_q, cnt1_d;
   logic [1:0]                 cnt2_q, cnt2_d;
   logic                       wr1_q, wr1_d, rd1_q, rd1_d;
   logic                       wr2_q, wr2_d, rd2_q, rd2_d;
   logic [1:0][OutWidth1-1:0]  mem1_q, mem1_d;
   logic [1:0][OutWidth2-1:0]  mem2_q, mem2_d;

   logic                       s_ready_w;
   logic                       push_w, pop1_w, pop2_w;
   logic [OutWidth1-1:0]       field1_w;
   logic [OutWidth2-1:0]       field2_w;

   // Ready depends only on registered occupancy, never on m_ready_x.
   assign s_ready_w = rst_done_q & (cnt1_q != 2'd2) & (cnt2_q != 2'd2);
   assign field1_w  = bus.s_data[InWidth-1:OutWidth2];
   assign field2_w  = bus.s_data[OutWidth2-1:0];

   assign bus.s_ready   = s_ready_w;
   assign bus.m_valid_1 = (cnt1_q != 2'd0);
   assign bus.m_valid_2 = (cnt2_q != 2'd0);
   assign bus.m_data_1  = mem1_q[rd1_q];
   assign bus.m_data_2  = mem2_q[rd2_q];

   always_comb begin
      push_w     = bus.s_valid & s_ready_w;
      pop1_w     = (cnt1_q != 2'd0) & bus.m_ready_1;
      pop2_w     = (cnt2_q != 2'd0) & bus.m_ready_2;
      rst_done_d = 1'b1;
      cnt1_d     = cnt1_q + {1'b0, push_w} - {1'b0, pop1_w};
      cnt2_d     = cnt2_q + {1'b0, push_w} - {1'b0, pop2_w};
      wr1_d      = wr1_q ^ push_w;
      wr2_d      = wr2_q ^ push_w;
      rd1_d      = rd1_q ^ pop1_w;
      rd2_d      = rd2_q ^ pop2_w;
      mem1_d     = mem1_q;
      mem2_d     = mem2_q;
      if (push_w) begin
         mem1_d[wr1_q] = field1_w;
         mem2_d[wr2_q] = field2_w;
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         rst_done_q <= 1'b0;
         cnt1_q     <= 2'd0;
         cnt2_q     <= 2'd0;
         wr1_q      <= 1'b0;
         wr2_q      <= 1'b0;
         rd1_q      <= 1'b0;
         rd2_q      <= 1'b0;
         mem1_q     <= '0;
         mem2_q     <= '0;
      end else begin
         rst_done_q <= rst_done_d;
         cnt1_q     <= cnt1_d;
         cnt2_q     <= cnt2_d;
         wr1_q      <= wr1_d;
         wr2_q      <= wr2_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         mem1_q     <= mem1_d;
         mem2_q     <= mem2_d;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_split_parallel.sv
// ============================================================================
// tb_split_parallel : directed plus random stimulus against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_split_parallel;
   logic clk = 1'b0;
   logic aresetn;

   split_parallel_if #(.OutWidth1(3), .OutWidth2(8)) bus ();

   split_parallel #(.OutWidth1(3), .OutWidth2(8)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: each branch is simply an ordered list of pending fields.
   logic [2:0] q1[$];
   logic [7:0] q2[$];
   logic       rst_done = 1'b0;
   logic       last_accepted = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic sv, input logic [10:0] d,
                       input logic r1, input logic r2, input logic rst_n);
      logic exp_rdy, do_push, do_pop1, do_pop2;
      @(negedge clk);
      exp_rdy = rst_done && (q1.size() < 2) && (q2.size() < 2);
      check("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
      check("m_valid_1", 32'(bus.m_valid_1), 32'(q1.size() != 0));
      check("m_valid_2", 32'(bus.m_valid_2), 32'(q2.size() != 0));
      if (q1.size() != 0) check("m_data_1", 32'(bus.m_data_1), 32'(q1[0]));
      if (q2.size() != 0) check("m_data_2", 32'(bus.m_data_2), 32'(q2[0]));
      bus.s_valid   = sv;
      bus.s_data    = d;
      bus.m_ready_1 = r1;
      bus.m_ready_2 = r2;
      aresetn       = rst_n;
      do_push = rst_n && sv && exp_rdy;
      do_pop1 = rst_n && r1 && (q1.size() != 0);
      do_pop2 = rst_n && r2 && (q2.size() != 0);
      @(posedge clk);
      if (!rst_n) begin
         q1.delete();
         q2.delete();
         rst_done = 1'b0;
      end else begin
         if (do_pop1) void'(q1.pop_front());
         if (do_pop2) void'(q2.pop_front());
         if (do_push) begin
            q1.push_back(d[10:8]);
            q2.push_back(d[7:0]);
         end
         rst_done = 1'b1;
      end
      last_accepted = do_push;
   endtask

   initial begin
      logic [10:0] w[4];
      logic [10:0] held;
      logic        pend;
      int          k;
      int          acc;

      aresetn       = 1'b0;
      bus.s_valid   = 1'b1;
      bus.s_data    = '0;
      bus.m_ready_1 = 1'b0;
      bus.m_ready_2 = 1'b0;
      @(posedge clk);

      // Reset held with s_valid=1, then release.
      step(1'b1, 11'h7ff, 1'b1, 1'b1, 1'b0);
      step(1'b1, 11'h7ff, 1'b1, 1'b1, 1'b0);
      step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);

      // Single word, then both branches pop.
      step(1'b1, 11'b111_10101010, 1'b1, 1'b1, 1'b1);
      step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);
      step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);

      // Back-to-back streaming.
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 11'(i * 13), 1'b1, 1'b1, 1'b1);
         if (last_accepted) acc++;
      end
      check("stream_accepts", 32'(acc), 32'd8);
      step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);
      step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);

      // Branch-2 stall with upstream holding the pending word.
      w[0] = 11'h101; w[1] = 11'h2c3; w[2] = 11'h4e5; w[3] = 11'h707;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, w[k], 1'b1, 1'b0, 1'b1);
         if (last_accepted) k++;
      end
      check("stall_accepts", 32'(k), 32'd2);
      step(1'b1, w[k], 1'b1, 1'b1, 1'b1);
      check("release_no_accept", 32'(last_accepted), 32'd0);
      step(1'b1, w[k], 1'b1, 1'b0, 1'b1);
      check("release_accept", 32'(last_accepted), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);

      // Fill both FIFOs, then pulse reset mid-operation.
      step(1'b1, 11'h3a5, 1'b0, 1'b0, 1'b1);
      step(1'b1, 11'h65a, 1'b0, 1'b0, 1'b1);
      step(1'b1, 11'h111, 1'b1, 1'b1, 1'b0);
      step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);
      step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);
      step(1'b1, 11'h0f0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);

      // Random traffic; upstream holds its word until accepted.
      pend = 1'b0;
      held = '0;
      for (int i = 0; i < 600; i++) begin
         logic sv, r1, r2, rn;
         rn = ($urandom_range(0, 79) != 0);
         if (!pend) begin
            sv   = ($urandom_range(0, 3) != 0);
            held = 11'($urandom);
         end else begin
            sv = 1'b1;
         end
         r1 = ($urandom_range(0, 2) != 0);
         r2 = ($urandom_range(0, 2) != 0);
         step(sv, held, r1, r2, rn);
         pend = sv && !last_accepted && rn;
      end
      for (int i = 0; i < 4; i++) step(1'b0, 11'h000, 1'b1, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/split_parallel.md
Name: split_parallel

Overview:
- Downstream companion of the parallel merge stage: consumes one merged valid/ready word and splits it into two independent valid/ready output streams.
- Each branch has its own 2-entry FIFO, so one stalled consumer does not block the other until its FIFO fills.
- s_ready is a function of registered occupancy only. There is no combinational path from m_ready_x to s_ready.

Parameters:
- OutWidth1, 3, width of branch-1 field and m_data_1
- OutWidth2, 8, width of branch-2 field and m_data_2
- InWidth, OutWidth1+OutWidth2 (11), input word width; localparam, not overridable

Ports:
- clk  input  1  clock, all state updates on rising edge
- aresetn  input  1  reset, synchronous, active-low
- s_valid  input  1  input word valid
- s_ready  output  1  input word accepted when s_valid & s_ready at a rising edge
- s_data  input  InWidth  merged word: [InWidth-1:OutWidth2] is the branch-1 field, [OutWidth2-1:0] is the branch-2 field
- m_valid_1  output  1  branch-1 head entry valid
- m_ready_1  input  1  branch-1 consumer ready
- m_data_1  output  OutWidth1  branch-1 head data
- m_valid_2  output  1  branch-2 head entry valid
- m_ready_2  input  1  branch-2 consumer ready
- m_data_2  output  OutWidth2  branch-2 head data

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - both FIFOs empty (count=0, pointers=0); m_valid_1=0, m_valid_2=0, s_ready=0 during reset cycles.
  - m_data_x is don't-care but must not be X after reset; data registers clear to 0.
- Reset asserted mid-operation: all buffered words are discarded, nothing is replayed, and the state matches a fresh reset.
- Per-branch FIFO x (x=1,2):
  - depth 2, count_x in {0,1,2}, write pointer and read pointer are 1 bit each.
  - m_valid_x = (count_x != 0); m_data_x = entry at the read pointer.
  - pop_x = m_valid_x & m_ready_x.
  - push = s_valid & s_ready; a push writes both FIFOs in the same edge.
  - count_x next = count_x + push - pop_x. Simultaneous push and pop leaves count unchanged and advances both pointers.
  - Pointers wrap 1 -> 0.
- s_ready = (count_1 != 2) & (count_2 != 2) & aresetn_reg.
  - aresetn_reg is a register set to 1 on the first edge after reset deasserts, so s_ready goes high one cycle after release.
  - s_ready does not look at m_ready_x. A full FIFO blocks input even if it pops the same cycle.
- Latency: a word accepted at edge N is visible as m_valid_x=1 with correct m_data_x in the cycle after edge N, on both branches together if both were empty.
- Throughput: 1 word/cycle sustained when both consumers hold m_ready=1.
- Ordering: each branch outputs fields in input order. The two branches may drift apart by up to 2 words.
- Backpressure:
  - branch x stalled: its FIFO fills after 2 accepts and s_ready drops.
  - the other branch keeps draining its buffered entries.
  - when the stalled branch pops, s_ready rises in the following cycle.
- Input protocol: s_valid=1 while s_ready=0 is legal; s_data is held by upstream. No word is lost or duplicated.
- Output protocol: m_valid_x=1 stays high and m_data_x stays stable until pop_x.

Test Plan:
- Reset: hold aresetn=0 for 2 cycles with s_valid=1 -> m_valid_1=m_valid_2=0 and s_ready=0 throughout; s_ready=1 one cycle after release.
- Single word, both m_ready=1:
  - s_data=11'b111_10101010 accepted at edge N -> after edge N, m_data_1=3'b111 and m_data_2=8'b10101010, both valid.
  - both branches pop the next edge, then m_valid_x=0.
- Streaming: 8 back-to-back words with s_data=i*13 (i=0..7), m_ready_x=1 -> s_ready stays 1, and each branch emits the matching slices in order at 1/cycle.
- Branch-2 stall:
  - m_ready_2=0, m_ready_1=1, stream 4 words -> exactly 2 accepted; s_ready=0 from the cycle after the 2nd accept.
  - branch 1 emits 2 words; m_valid_2 stays 1 with word 0 stable.
- Release stall: set m_ready_2=1 for one cycle -> branch 2 pops word 0, s_ready=1 the next cycle, word 2 is accepted; no loss or duplication in either branch sequence.
- Mid-operation reset: with both FIFOs full, pulse aresetn=0 for 1 cycle -> m_valid_x=0 next cycle and s_ready=0; no stale word appears after release.
